// File: rtl/softmax_row_sched.sv
// softmax_row_sched: walks a job of score rows through an external softmax
// unit. For each row it reads the score buffer, presents the row to the
// softmax unit with a level start, waits for the result (bounded by TIMEOUT)
// and writes it to the result buffer at the same row index.
//
// Ports
//   I_CLK / I_RST_N            clock, async active-low reset
//   I_START, I_ROWS            job start pulse and row count (0 = empty job)
//   O_BUSY, O_DONE, O_ERR      status; O_ERR is a sticky timeout flag
//   O_RD_EN/ADDR, I_RD_DATA    score-buffer read (data one cycle after strobe)
//   O_SM_START/DATA            softmax operand, start held high only in RUN
//   I_SM_VLD/DATA              softmax result
//   O_WR_EN/ADDR/DATA          result-buffer write

// One element lane: holds the softmax operand and the captured result.
module softmax_row_sched_lane #(
  parameter int D_W = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_ld_op,
  input  logic           i_ld_res,
  input  logic [D_W-1:0] i_rd_data,
  input  logic [D_W-1:0] i_sm_data,
  output logic [D_W-1:0] o_op,
  output logic [D_W-1:0] o_res
);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_op  <= '0;
      o_res <= '0;
    end else begin
      if (i_ld_op)  o_op  <= i_rd_data;
      if (i_ld_res) o_res <= i_sm_data;
    end
  end
endmodule

module softmax_row_sched #(
  parameter int D_W     = 16,
  parameter int DIM     = 4,
  parameter int ROW_AW  = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic                 I_CLK,
  input  logic                 I_RST_N,
  input  logic                 I_START,
  input  logic [ROW_AW:0]      I_ROWS,
  output logic                 O_BUSY,
  output logic                 O_DONE,
  output logic                 O_ERR,
  output logic                 O_RD_EN,
  output logic [ROW_AW-1:0]    O_RD_ADDR,
  input  logic [D_W*DIM-1:0]   I_RD_DATA,
  output logic                 O_SM_START,
  output logic [D_W*DIM-1:0]   O_SM_DATA,
  input  logic                 I_SM_VLD,
  input  logic [D_W*DIM-1:0]   I_SM_DATA,
  output logic                 O_WR_EN,
  output logic [ROW_AW-1:0]    O_WR_ADDR,
  output logic [D_W*DIM-1:0]   O_WR_DATA
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_RUN, S_WRITE, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic [ROW_AW:0]      r_rows;
  logic [ROW_AW-1:0]    r_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_err;

  logic                 w_start_acc;
  logic                 w_last;
  logic                 w_tmo;
  logic                 w_ld_op;
  logic                 w_ld_res;

  logic [DIM-1:0][D_W-1:0] w_rd, w_sm, w_op, w_res;

  assign w_start_acc = (r_state == S_IDLE) && I_START;
  assign w_last      = ({1'b0, r_idx} == r_rows - (ROW_AW+1)'(1));
  // True on the RUN cycle whose missing valid would bring the count to TIMEOUT.
  assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_ld_op     = (r_state == S_LOAD);
  // A valid on the timeout cycle still wins: the capture has priority.
  assign w_ld_res    = (r_state == S_RUN) && I_SM_VLD;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (I_START) w_next = (I_ROWS == '0) ? S_DONE : S_READ;
      S_READ:  w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   if (I_SM_VLD) w_next = S_WRITE;
               else if (w_tmo) w_next = S_DONE;
      S_WRITE: w_next = w_last ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_state <= S_IDLE;
      r_rows  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_rows <= I_ROWS;
        r_idx  <= '0;
        r_err  <= 1'b0;
      end
      if (r_state == S_WRITE && !w_last) r_idx <= r_idx + ROW_AW'(1);
      // LOAD always precedes RUN, so clearing here is clearing on RUN entry.
      if (r_state == S_LOAD) r_cnt <= '0;
      else if (r_state == S_RUN && !I_SM_VLD) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_RUN && !I_SM_VLD && w_tmo) r_err <= 1'b1;
    end
  end

  assign w_rd = I_RD_DATA;
  assign w_sm = I_SM_DATA;

  for (genvar l = 0; l < DIM; l++) begin : g_lane
    softmax_row_sched_lane #(.D_W(D_W)) u_lane (
      .i_clk     (I_CLK),
      .i_rst_n   (I_RST_N),
      .i_ld_op   (w_ld_op),
      .i_ld_res  (w_ld_res),
      .i_rd_data (w_rd[l]),
      .i_sm_data (w_sm[l]),
      .o_op      (w_op[l]),
      .o_res     (w_res[l])
    );
  end

  // Status and strobes decode straight from state, so reset drops them
  // asynchronously with the state register.
  assign O_BUSY     = (r_state != S_IDLE);
  assign O_DONE     = (r_state == S_DONE);
  assign O_ERR      = r_err;
  assign O_RD_EN    = (r_state == S_READ);
  assign O_RD_ADDR  = r_idx;
  assign O_SM_START = (r_state == S_RUN);
  assign O_SM_DATA  = w_op;
  assign O_WR_EN    = (r_state == S_WRITE);
  assign O_WR_ADDR  = r_idx;
  assign O_WR_DATA  = w_res;
endmodule

// File: tb/tb_softmax_row_sched.sv
module tb_softmax_row_sched;
  localparam int D_W = 16, DIM = 4, ROW_AW = 6, TMO = 15;
  localparam int NR = 1 << ROW_AW, DW = D_W * DIM;

  logic                I_CLK = 1'b0, I_RST_N = 1'b0, I_START = 1'b0;
  logic [ROW_AW:0]     I_ROWS = '0;
  logic                O_BUSY, O_DONE, O_ERR, O_RD_EN, O_SM_START, O_WR_EN;
  logic [ROW_AW-1:0]   O_RD_ADDR, O_WR_ADDR;
  logic [DW-1:0]       I_RD_DATA, O_SM_DATA, I_SM_DATA, O_WR_DATA;
  logic                I_SM_VLD;

  always #5 I_CLK = ~I_CLK;

  softmax_row_sched #(.D_W(D_W), .DIM(DIM), .ROW_AW(ROW_AW), .TIMEOUT(TMO)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_START(I_START), .I_ROWS(I_ROWS),
    .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR),
    .O_RD_EN(O_RD_EN), .O_RD_ADDR(O_RD_ADDR), .I_RD_DATA(I_RD_DATA),
    .O_SM_START(O_SM_START), .O_SM_DATA(O_SM_DATA),
    .I_SM_VLD(I_SM_VLD), .I_SM_DATA(I_SM_DATA),
    .O_WR_EN(O_WR_EN), .O_WR_ADDR(O_WR_ADDR), .O_WR_DATA(O_WR_DATA));

  // ---------------- environment: score buffer and softmax stub ----------------
  logic [DW-1:0] mem [NR];
  int            dly [NR];   // RUN cycle (1-based) on which the stub answers; 0 = never
  logic [DW-1:0] key;        // stub result = operand ^ key
  int            cur_row = 0, stub_cnt = 0;
  logic          noise = 1'b0;
  logic [DW-1:0] junk_sm = '0;
  logic          w_hit;

  always @(posedge I_CLK) begin
    I_RD_DATA <= O_RD_EN ? mem[O_RD_ADDR] : {$urandom, $urandom};
    if (O_RD_EN) cur_row <= int'(O_RD_ADDR);
    stub_cnt <= O_SM_START ? stub_cnt + 1 : 0;
    noise    <= ($urandom_range(0, 3) == 0);
    junk_sm  <= {$urandom, $urandom};
  end

  assign w_hit     = O_SM_START && (dly[cur_row] != 0) && (stub_cnt + 1 == dly[cur_row]);
  assign I_SM_VLD  = O_SM_START ? w_hit : noise;   // noise outside RUN must be ignored
  assign I_SM_DATA = w_hit ? (O_SM_DATA ^ key) : junk_sm;

  // ---------------- scoreboard ----------------
  typedef struct { int addr; logic [DW-1:0] data; int lat; } wr_t;
  typedef struct { bit err; int run_len; } done_t;
  int    rd_q[$];
  wr_t   wr_q[$];
  done_t done_q[$];
  int    n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input bit ok, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: row r is read, then written with mem[r]^key after
  // READ+LOAD+dly[r] cycles, unless the stub never answers within TMO RUN
  // cycles, in which case the job ends with the error flag and no write.
  task automatic model(input int rows);
    bit err = 0;
    wr_t w;
    done_t d;
    for (int r = 0; r < rows; r++) begin
      rd_q.push_back(r);
      if (dly[r] >= 1 && dly[r] <= TMO) begin
        w.addr = r; w.data = mem[r] ^ key; w.lat = 2 + dly[r];
        wr_q.push_back(w);
      end else begin
        err = 1;
        break;
      end
    end
    d.err = err; d.run_len = err ? TMO : 0;
    done_q.push_back(d);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0, rd_cyc = 0, run_len = 0, low_run = 3;
  logic [DW-1:0] op_cap = '0;
  bit prev_start = 0;

  always @(posedge I_CLK) cyc <= cyc + 1;

  always @(negedge I_CLK) begin : mon
    int e;
    wr_t w;
    done_t d;
    if (I_RST_N) begin
      if (O_RD_EN) begin
        if (rd_q.size() == 0) chk("unexpected_read", 0, O_RD_ADDR, 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_addr", O_RD_ADDR === ROW_AW'(e), O_RD_ADDR, ROW_AW'(e));
        end
        rd_cyc = cyc;
      end
      if (O_SM_START) begin
        if (!prev_start) begin
          chk("sm_gap", low_run >= 3, low_run, 3);
          chk("sm_operand", O_SM_DATA === mem[cur_row], O_SM_DATA, mem[cur_row]);
          op_cap  = O_SM_DATA;
          run_len = 0;
        end else
          chk("sm_stable", O_SM_DATA === op_cap, O_SM_DATA, op_cap);
        run_len++;
        low_run = 0;
      end else
        low_run++;
      prev_start = O_SM_START;
      if (O_WR_EN) begin
        if (wr_q.size() == 0) chk("unexpected_write", 0, O_WR_ADDR, 0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", O_WR_ADDR === ROW_AW'(w.addr), O_WR_ADDR, ROW_AW'(w.addr));
          chk("wr_data", O_WR_DATA === w.data, O_WR_DATA, w.data);
          chk("wr_latency", cyc - rd_cyc == w.lat, cyc - rd_cyc, w.lat);
        end
      end
      if (O_DONE) begin
        if (done_q.size() == 0) chk("unexpected_done", 0, O_DONE, 0);
        else begin
          d = done_q.pop_front();
          chk("done_err", O_ERR === d.err, O_ERR, d.err);
          if (d.run_len > 0) chk("timeout_run_len", run_len == d.run_len, run_len, d.run_len);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_dly(input int v);
    for (int i = 0; i < NR; i++) dly[i] = v;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {O_BUSY, O_DONE, O_ERR, O_RD_EN, O_SM_START, O_WR_EN} === 6'b0,
        {O_BUSY, O_DONE, O_ERR, O_RD_EN, O_SM_START, O_WR_EN}, 0);
    chk({tag, "_addr"}, {O_RD_ADDR, O_WR_ADDR} === '0, {O_RD_ADDR, O_WR_ADDR}, 0);
    chk({tag, "_smdata"}, O_SM_DATA === '0, O_SM_DATA, 0);
    chk({tag, "_wrdata"}, O_WR_DATA === '0, O_WR_DATA, 0);
  endtask

  task automatic pulse_start(input int rows);
    @(negedge I_CLK);
    I_START = 1'b1;
    I_ROWS  = (ROW_AW+1)'(rows);
    @(negedge I_CLK);
    I_START = 1'b0;
    chk("start_err_clr", O_ERR === 1'b0, O_ERR, 0);
    chk("start_busy", O_BUSY === 1'b1, O_BUSY, 1);
    if (rows == 0) chk("zero_row_done", O_DONE === 1'b1, O_DONE, 1);
  endtask

  task automatic run_job(input int rows, input bit noisy);
    int budget;
    key = {$urandom, $urandom};
    model(rows);
    pulse_start(rows);
    budget = rows * (TMO + 8) + 20;
    while (O_DONE !== 1'b1 && budget > 0) begin
      I_START = noisy && ($urandom_range(0, 5) == 0);  // must be ignored while busy
      I_ROWS  = (ROW_AW+1)'($urandom);
      @(negedge I_CLK);
      budget--;
    end
    if (O_DONE !== 1'b1) chk("done_wait_expired", 0, O_DONE, 1);
    I_START = noisy;   // start during DONE must also be ignored
    @(negedge I_CLK);
    I_START = 1'b0;
    chk("idle_after_done", {O_BUSY, O_DONE} === 2'b00, {O_BUSY, O_DONE}, 0);
  endtask

  initial begin
    int budget;
    for (int i = 0; i < NR; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h8000_9000_A000_B000;   // {-2.5,-3,-3.5,-4}, lane 0 in the low bits
    set_dly(6);                         // valid 5 cycles after start rises
    key = '0;

    repeat (3) @(negedge I_CLK);
    chk_reset_outputs("reset");
    I_RST_N = 1'b1;
    @(negedge I_CLK);

    run_job(1, 0);                      // single row
    run_job(4, 0);                      // multi row
    run_job(0, 0);                      // empty job

    dly[1] = 0;                         // stub never answers on row 1
    run_job(3, 0);
    repeat (4) @(negedge I_CLK);
    chk("err_sticky", O_ERR === 1'b1, O_ERR, 1);
    dly[1] = 6;
    run_job(2, 0);                      // next start clears the flag

    dly[0] = TMO; dly[1] = 1;           // valid on the timeout cycle, then fastest
    run_job(2, 0);
    dly[0] = TMO + 1;                   // one cycle too late
    run_job(1, 0);
    set_dly(6);

    run_job(4, 1);                      // starts while busy

    for (int i = 0; i < NR; i++) dly[i] = $urandom_range(1, TMO);
    run_job(NR, 1);                     // full address range

    repeat (20) begin
      for (int i = 0; i < NR; i++) dly[i] = $urandom_range(1, TMO);
      if ($urandom_range(0, 4) == 0) dly[$urandom_range(0, 7)] = 0;
      run_job($urandom_range(0, 8), 1'($urandom_range(0, 1)));
    end

    // Reset during RUN of row 2.
    set_dly(10);
    key = {$urandom, $urandom};
    model(4);
    pulse_start(4);
    budget = 200;
    while (!(O_SM_START === 1'b1 && cur_row == 2) && budget > 0) begin
      @(negedge I_CLK);
      budget--;
    end
    if (budget == 0) chk("reach_row2_expired", 0, cur_row, 2);
    I_RST_N = 1'b0;
    #1;
    chk_reset_outputs("midjob_reset");
    rd_q.delete(); wr_q.delete(); done_q.delete();
    repeat (3) @(negedge I_CLK);
    chk_reset_outputs("held_reset");
    I_RST_N = 1'b1;
    repeat (2) @(negedge I_CLK);
    chk("no_done_after_reset", O_DONE === 1'b0, O_DONE, 0);
    set_dly(6);
    run_job(3, 0);                      // must restart at address 0

    repeat (5) @(negedge I_CLK);
    chk("rd_q_empty", rd_q.size() == 0, rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size() == 0, wr_q.size(), 0);
    chk("done_q_empty", done_q.size() == 0, done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
